// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB writeback stage, the ID read ports and the
// GPR/HILO register file.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] wb_wd;
  logic              wb_wreg;
  logic [DATA_W-1:0] wb_wdata;
  logic              wb_whilo;
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
    output re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, hi_o, lo_o
  );

  modport slave (
    input  wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
    input  re1, raddr1, re2, raddr2,
    output rdata1, rdata2, hi_o, lo_o
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback-side GPR file (r0 hardwired to zero) plus HI/LO pair, with two
// combinational read ports that forward the write retiring this cycle.
module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic          clk,
  input  logic          rst,
  wb_regfile_if.slave   bus
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // Storage must clear on reset, which keeps it out of block RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (bus.wb_wreg && (bus.wb_wd != '0)) begin
        regs[bus.wb_wd] <= bus.wb_wdata;
      end
      if (bus.wb_whilo) begin
        hi_q <= bus.wb_hi;
        lo_q <= bus.wb_lo;
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic              rst_i,
    input logic              re,
    input logic [ADDR_W-1:0] ra,
    input logic              wreg,
    input logic [ADDR_W-1:0] wd,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    if (rst_i || !re || (ra == '0)) begin
      return '0;
    end else if (wreg && (wd == ra)) begin
      return wdata;
    end else begin
      return stored;
    end
  endfunction

  assign bus.rdata1 = read_port(rst, bus.re1, bus.raddr1, bus.wb_wreg, bus.wb_wd,
                                bus.wb_wdata, regs[bus.raddr1]);
  assign bus.rdata2 = read_port(rst, bus.re2, bus.raddr2, bus.wb_wreg, bus.wb_wd,
                                bus.wb_wdata, regs[bus.raddr2]);

  // HI/LO are not forwarded; EX handles in-flight HILO writes.
  assign bus.hi_o = rst ? '0 : hi_q;
  assign bus.lo_o = rst ? '0 : lo_q;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-side sink for the MEM/WB pipeline register. It consumes wb_wd/wb_wreg/wb_wdata and wb_whilo/wb_hi/wb_lo.
- Holds the 32-entry general-purpose register file and the HI/LO register pair.
- Serves two combinational read ports to ID, with same-cycle write-to-read bypass.
- Sits at the tail of the openMIPS pipeline; every retired GPR or HILO write lands here.

Parameters:
- DATA_W, 32, width of GPR, HI and LO data
- ADDR_W, 5, GPR address width
- NUM_REGS, 32, number of GPR entries; must equal 2**ADDR_W

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- wb_wd  input  ADDR_W  GPR write address from MEM/WB
- wb_wreg  input  1  GPR write enable from MEM/WB
- wb_wdata  input  DATA_W  GPR write data
- wb_whilo  input  1  HI/LO write enable
- wb_hi  input  DATA_W  HI write data
- wb_lo  input  DATA_W  LO write data
- re1  input  1  read enable, port 1
- raddr1  input  ADDR_W  read address, port 1
- rdata1  output  DATA_W  read data, port 1 (combinational)
- re2  input  1  read enable, port 2
- raddr2  input  ADDR_W  read address, port 2
- rdata2  output  DATA_W  read data, port 2 (combinational)
- hi_o  output  DATA_W  current HI register (registered)
- lo_o  output  DATA_W  current LO register (registered)

Behaviour:
- Reset: reset rst, synchronous, active-high; clock clk.
  - On a clk edge with rst=1: all NUM_REGS GPR entries, HI and LO are cleared to 0.
  - Pending writes in the same cycle are discarded; reset wins over any write.
  - While rst=1: rdata1, rdata2, hi_o and lo_o all read 0.
  - hi_o/lo_o are 0 in the first cycle after reset deasserts.
- GPR write:
  - On a clk edge with rst=0, wb_wreg=1 and wb_wd!=0: reg[wb_wd] <= wb_wdata.
  - Write latency is 1 edge; the value is visible from storage in the following cycle.
- Register 0 is hardwired to 0. A write with wb_wd=0 is ignored, and reads of address 0 always return 0, even with bypass conditions met.
- Read port n (n=1,2), evaluated combinationally in priority order:
  - rst=1 -> 0
  - re_n=0 -> 0
  - raddr_n=0 -> 0
  - wb_wreg=1 and wb_wd==raddr_n -> wb_wdata (bypass: the write in flight this cycle is forwarded)
  - otherwise -> reg[raddr_n]
- Both ports are fully independent. The same address on both ports returns identical data, including the bypassed value.
- HI/LO write: on a clk edge with rst=0 and wb_whilo=1, HI <= wb_hi and LO <= wb_lo together. There is no partial update.
- hi_o/lo_o are the register values with no bypass; EX-stage forwarding covers in-flight HILO writes.
- Independence: GPR and HILO writes in the same cycle both take effect.
- Pipeline stalls and NOPs:
  - No stall input is needed; a stalled or NOP writeback arrives as wb_wreg=0 and wb_whilo=0.
  - With both enables low, state holds indefinitely.
- Don't-care data: wb_wdata is ignored when wb_wreg=0. wb_hi/wb_lo are ignored when wb_whilo=0. No X may propagate into storage from disabled writes.
- Storage: a register array of NUM_REGS x DATA_W, inferable as flops or distributed RAM. Reset clearing is required, so a block-RAM mapping is not permitted.

Test Plan:
- Reset and clear:
  - Stimulus: assert rst for 2 cycles while driving wb_wreg=1, wb_wd=5, wb_wdata=0xDEADBEEF. Deassert rst, then read raddr1=5 with re1=1.
  - Required: rdata1=0; hi_o=lo_o=0.
- Write then read:
  - Stimulus: write reg 7 <= 0x12345678. Next cycle, re1=1, raddr1=7.
  - Required: rdata1=0x12345678. With re1=0, rdata1=0.
- Bypass:
  - Stimulus: in one cycle, wb_wreg=1, wb_wd=3, wb_wdata=0xA5A5A5A5, with re2=1, raddr2=3 (reg3 previously 0x11111111).
  - Required: rdata2=0xA5A5A5A5 in that same cycle, and reg3 holds 0xA5A5A5A5 afterwards.
- Register zero:
  - Stimulus: write wb_wd=0, wb_wdata=0xFFFFFFFF, while reading raddr1=raddr2=0 with re1=re2=1.
  - Required: rdata1=rdata2=0 in that cycle and the next.
- HILO:
  - Stimulus: wb_whilo=1, wb_hi=0x00000001, wb_lo=0x80000000, together with a GPR write to reg 9.
  - Required: after the edge, hi_o=0x00000001, lo_o=0x80000000, and reg9 is updated.
  - Follow-up: wb_whilo=0 with new wb_hi/wb_lo values -> hi_o/lo_o unchanged.
- Reset mid-stream:
  - Stimulus: fill regs 1..31 with their own index, then assert rst for one cycle during a write to reg 4.
  - Required: all reads return 0 afterwards and hi_o=lo_o=0.
